// File: rtl/cp0_int_ctrl_if.sv
// cp0_int_ctrl_if: CP0 register-bus, exception/interrupt request and catch signals.
interface cp0_int_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 30,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int N_INTS         = 8
);
  logic                      i_en;
  logic [REG_ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0]     i_din;
  logic                      i_rfe_en;
  logic [4:0]                i_exceptions;
  logic                      i_delay_slot;
  logic [N_INTS-1:0]         i_interrupts;
  logic [PC_WIDTH-1:0]       i_pc;
  logic [DATA_WIDTH-1:0]     o_dout;
  logic [PC_WIDTH-1:0]       o_epc;
  logic                      o_ie_catch;
  logic                      o_int_only;
  logic [4:0]                o_code;
  logic                      o_timer_irq;
  modport master (
    output i_en, i_address, i_din, i_rfe_en, i_exceptions, i_delay_slot, i_interrupts, i_pc,
    input  o_dout, o_epc, o_ie_catch, o_int_only, o_code, o_timer_irq
  );
  modport slave (
    input  i_en, i_address, i_din, i_rfe_en, i_exceptions, i_delay_slot, i_interrupts, i_pc,
    output o_dout, o_epc, o_ie_catch, o_int_only, o_code, o_timer_irq
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: CP0 exception/interrupt controller with IE save stack and edge/level sources.
// Define CP0_TIMER_EN to add the COUNT/COMPARE timer feeding source TIMER_IRQ.
module cp0_int_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 30,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int N_INTS         = 8,
  parameter int IE_DEPTH       = 3,
  parameter int TIMER_IRQ      = 7
) (
  input logic           i_clk,
  input logic           i_arst_n,
  cp0_int_ctrl_if.slave bus
);
  localparam logic [REG_ADDR_WIDTH-1:0] A_COUNT   = REG_ADDR_WIDTH'(9);
  localparam logic [REG_ADDR_WIDTH-1:0] A_COMPARE = REG_ADDR_WIDTH'(11);
  localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS  = REG_ADDR_WIDTH'(12);
  localparam logic [REG_ADDR_WIDTH-1:0] A_CAUSE   = REG_ADDR_WIDTH'(13);
  localparam logic [REG_ADDR_WIDTH-1:0] A_EPC     = REG_ADDR_WIDTH'(14);
  localparam logic [REG_ADDR_WIDTH-1:0] A_MODE    = REG_ADDR_WIDTH'(15);
  logic [4:0]            r_exc_mask, r_cause_exc, r_code;
  logic [IE_DEPTH-1:0]   r_ie;
  logic [N_INTS-1:0]     r_int_mask, r_mode, r_pend, r_int_ff;
  logic                  r_bd;
  logic [PC_WIDTH-1:0]   r_epc;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [N_INTS-1:0]     w_irq, w_rise, w_pend, w_int_req, w_int_hot, w_w1c, w_clr;
  logic [4:0]            w_exc_req, w_code;
  logic                  w_catch, w_int_only, w_wr_status, w_wr_epc, w_wr_mode;
  logic [DATA_WIDTH-1:0] w_rd;
  assign w_wr_status = bus.i_en && bus.i_address == A_STATUS;
  assign w_wr_epc    = bus.i_en && bus.i_address == A_EPC;
  assign w_wr_mode   = bus.i_en && bus.i_address == A_MODE;
  assign w_w1c       = (bus.i_en && bus.i_address == A_CAUSE) ? bus.i_din[16 +: N_INTS] : '0;
`ifdef CP0_TIMER_EN
  logic [DATA_WIDTH-1:0] r_count, r_compare;
  logic                  r_timer_irq;
  logic                  w_wr_count, w_wr_compare;
  assign w_wr_count   = bus.i_en && bus.i_address == A_COUNT;
  assign w_wr_compare = bus.i_en && bus.i_address == A_COMPARE;
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      r_count     <= '0;
      r_compare   <= '0;
      r_timer_irq <= 1'b0;
    end else begin
      r_count     <= w_wr_count ? bus.i_din : r_count + 1'b1;
      r_compare   <= w_wr_compare ? bus.i_din : r_compare;
      r_timer_irq <= (r_count == r_compare) | (r_timer_irq & ~w_wr_compare);
    end
  assign bus.o_timer_irq = r_timer_irq;
  assign w_irq = bus.i_interrupts | (N_INTS'(r_timer_irq) << TIMER_IRQ);
`else
  assign bus.o_timer_irq = 1'b0;
  assign w_irq = bus.i_interrupts;
`endif
  // level sources bypass the latch and follow the live line
  assign w_rise     = w_irq & ~r_int_ff;
  assign w_pend     = (r_mode & r_pend) | (~r_mode & w_irq);
  assign w_exc_req  = bus.i_exceptions & r_exc_mask;
  assign w_int_req  = w_pend & r_int_mask & {N_INTS{r_ie[0]}};
  assign w_catch    = |w_exc_req | |w_int_req;
  assign w_int_only = ~|w_exc_req & |w_int_req;
  assign w_clr      = w_w1c | (w_int_only ? w_int_hot : '0);
  always_comb begin
    w_code    = '0;
    w_int_hot = '0;
    for (int k = N_INTS - 1; k >= 0; k--)
      if (w_int_req[k]) begin
        w_code    = 5'(16 + k);
        w_int_hot = N_INTS'(1) << k;
      end
    for (int k = 4; k >= 0; k--)
      if (w_exc_req[k]) w_code = 5'(k);
  end
  always_comb begin
    w_rd = '0;
    case (bus.i_address)
      A_STATUS: begin
        w_rd[4:0]           = r_exc_mask;
        w_rd[8 +: IE_DEPTH] = r_ie;
        w_rd[16 +: N_INTS]  = r_int_mask;
      end
      A_CAUSE: begin
        w_rd[4:0]          = r_cause_exc;
        w_rd[5]            = r_bd;
        w_rd[12:8]         = r_code;
        w_rd[16 +: N_INTS] = w_pend;
      end
      A_EPC:     w_rd[PC_WIDTH+1:2] = r_epc;
      A_MODE:    w_rd[N_INTS-1:0]   = r_mode;
`ifdef CP0_TIMER_EN
      A_COUNT:   w_rd = r_count;
      A_COMPARE: w_rd = r_compare;
`endif
      default:   w_rd = '0;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      r_exc_mask  <= 5'h1f;
      r_ie        <= '1;
      r_int_mask  <= '1;
      r_mode      <= '1;
      r_pend      <= '0;
      r_int_ff    <= '0;
      r_cause_exc <= '0;
      r_bd        <= 1'b0;
      r_code      <= '0;
      r_epc       <= '0;
      r_dout      <= '0;
    end else begin
      r_int_ff <= w_irq;
      r_pend   <= ((r_pend & ~w_clr) | w_rise) & r_mode;
      r_dout   <= w_rd;
      r_ie     <= w_catch ? {r_ie[IE_DEPTH-2:0], 1'b0} :
                  bus.i_rfe_en ? {1'b1, r_ie[IE_DEPTH-1:1]} :
                  w_wr_status ? bus.i_din[8 +: IE_DEPTH] : r_ie;
      r_epc    <= w_catch ? bus.i_pc : w_wr_epc ? bus.i_din[PC_WIDTH+1:2] : r_epc;
      if (w_wr_status) begin
        r_exc_mask <= bus.i_din[4:0];
        r_int_mask <= bus.i_din[16 +: N_INTS];
      end
      if (w_wr_mode) r_mode <= bus.i_din[N_INTS-1:0];
      if (w_catch) begin
        r_cause_exc <= w_exc_req;
        r_bd        <= bus.i_delay_slot;
        r_code      <= w_code;
      end
    end
  assign bus.o_dout     = r_dout;
  assign bus.o_epc      = r_epc;
  assign bus.o_ie_catch = w_catch;
  assign bus.o_int_only = w_int_only;
  assign bus.o_code     = w_code;
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb_cp0_int_ctrl: directed vectors with hand-computed expectations for cp0_int_ctrl.
module tb_cp0_int_ctrl;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  cp0_int_ctrl_if #(.DATA_WIDTH(32), .PC_WIDTH(30), .REG_ADDR_WIDTH(5), .N_INTS(8)) bus ();
  cp0_int_ctrl #(.DATA_WIDTH(32), .PC_WIDTH(30), .REG_ADDR_WIDTH(5), .N_INTS(8),
                 .IE_DEPTH(3), .TIMER_IRQ(7)) dut (.i_clk(clk), .i_arst_n(arst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.i_en = 1'b1;
    bus.i_address = a;
    bus.i_din = d;
    @(negedge clk);
    bus.i_en = 1'b0;
    bus.i_din = '0;
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.i_address = a;
    @(negedge clk);
    d = bus.o_dout;
  endtask
  task automatic exc_pulse(input logic [4:0] e);
    bus.i_exceptions = e;
    @(negedge clk);
    bus.i_exceptions = '0;
  endtask
  task automatic rfe_pulse();
    bus.i_rfe_en = 1'b1;
    @(negedge clk);
    bus.i_rfe_en = 1'b0;
  endtask
  task automatic int_pulse(input logic [7:0] v);
    bus.i_interrupts = v;
    @(negedge clk);
    bus.i_interrupts = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d;
    logic [2:0] ie_push [3];
    logic [2:0] ie_pop [3];
    bit hit;
    ie_push = '{3'b110, 3'b100, 3'b000};
    ie_pop  = '{3'b100, 3'b110, 3'b111};
    bus.i_en = 1'b0; bus.i_address = '0; bus.i_din = '0; bus.i_rfe_en = 1'b0;
    bus.i_exceptions = '0; bus.i_delay_slot = 1'b0; bus.i_interrupts = '0; bus.i_pc = '0;
    #12 arst_n = 1'b1;
    @(negedge clk);
    check("rst_dout", bus.o_dout, 32'h0);
    check("rst_catch", 32'(bus.o_ie_catch), 32'h0);
    check("rst_timer", 32'(bus.o_timer_irq), 32'h0);
    rd(5'd12, d); check("rst_status", d, 32'h00FF071F);
    rd(5'd13, d); check("rst_cause", d, 32'h0);
    rd(5'd14, d); check("rst_epc", d, 32'h0);
    rd(5'd15, d); check("rst_mode", d, 32'h000000FF);
    rd(5'd3, d);  check("unmapped", d, 32'h0);
    // edge interrupt on source 3
    bus.i_interrupts = 8'h08; bus.i_pc = 30'h100;
    @(negedge clk);
    bus.i_interrupts = '0; #1;
    check("t1_catch", 32'(bus.o_ie_catch), 32'h1);
    check("t1_int_only", 32'(bus.o_int_only), 32'h1);
    check("t1_code", 32'(bus.o_code), 32'd19);
    @(negedge clk); #1;
    check("t1_after", 32'(bus.o_ie_catch), 32'h0);
    check("t1_epc_port", 32'(bus.o_epc), 32'h100);
    rd(5'd14, d); check("t1_epc", d, 32'h400);
    rd(5'd13, d); check("t1_cause", d, 32'h00001300);
    rd(5'd12, d); check("t1_status", d, 32'h00FF061F);
    rfe_pulse();
    rd(5'd12, d); check("t1_rfe", d, 32'h00FF071F);
    // exception beats a simultaneous interrupt edge
    bus.i_exceptions = 5'b00100; bus.i_interrupts = 8'h01; bus.i_pc = 30'h200; bus.i_delay_slot = 1'b1; #1;
    check("t2_code", 32'(bus.o_code), 32'd2);
    check("t2_int_only", 32'(bus.o_int_only), 32'h0);
    @(negedge clk);
    bus.i_exceptions = '0; bus.i_interrupts = '0; bus.i_delay_slot = 1'b0; #1;
    check("t2_blocked", 32'(bus.o_ie_catch), 32'h0);
    rd(5'd13, d); check("t2_cause", d, 32'h00010224);
    rd(5'd14, d); check("t2_epc", d, 32'h800);
    bus.i_pc = 30'h300;
    rfe_pulse(); #1;
    check("t2_late_catch", 32'(bus.o_ie_catch), 32'h1);
    check("t2_late_code", 32'(bus.o_code), 32'd16);
    @(negedge clk); #1;
    check("t2_cleared", 32'(bus.o_ie_catch), 32'h0);
    rd(5'd14, d); check("t2_epc2", d, 32'hC00);
    rfe_pulse();
    // nested exceptions then unwinding
    for (int i = 0; i < 3; i++) begin
      exc_pulse(5'b00010);
      rd(5'd12, d); check("t3_push", d, 32'h00FF001F | (32'(ie_push[i]) << 8));
    end
    for (int i = 0; i < 3; i++) begin
      rfe_pulse();
      rd(5'd12, d); check("t3_pop", d, 32'h00FF001F | (32'(ie_pop[i]) << 8));
    end
    bus.i_rfe_en = 1'b1;
    exc_pulse(5'b00010);
    bus.i_rfe_en = 1'b0;
    rd(5'd12, d); check("catch_over_rfe", d, 32'h00FF061F);
    rfe_pulse();
    bus.i_pc = 30'h55; bus.i_en = 1'b1; bus.i_address = 5'd14; bus.i_din = 32'hABC4;
    exc_pulse(5'b00010);
    bus.i_en = 1'b0;
    rd(5'd14, d); check("epc_wr_dropped", d, 32'h154);
    rfe_pulse();
    wr(5'd14, 32'h0000ABC7);
    rd(5'd14, d); check("epc_wr", d, 32'hABC4);
    wr(5'd12, 32'h00FF071E);
    bus.i_exceptions = 5'b00001; #1;
    check("exc_masked", 32'(bus.o_ie_catch), 32'h0);
    bus.i_exceptions = '0;
    wr(5'd12, 32'h00FF071F);
    // level source 5
    wr(5'd15, 32'h000000DF);
    wr(5'd12, 32'h00DF071F);
    bus.i_interrupts = 8'h20; #1;
    check("t4_masked", 32'(bus.o_ie_catch), 32'h0);
    wr(5'd12, 32'h00FF071F); #1;
    check("t4_catch", 32'(bus.o_ie_catch), 32'h1);
    check("t4_code", 32'(bus.o_code), 32'd21);
    bus.i_interrupts = '0; #1;
    check("t4_drop", 32'(bus.o_ie_catch), 32'h0);
    rd(5'd13, d); check("t4_pend", 32'(d[23:16]), 32'h0);
    wr(5'd15, 32'h000000FF);
    // W1C of a pending edge
    exc_pulse(5'b00001);
    int_pulse(8'h04); #1;
    check("t5_blocked", 32'(bus.o_ie_catch), 32'h0);
    rd(5'd13, d); check("t5_pend", 32'(d[23:16]), 32'h04);
    wr(5'd13, 32'h00040000);
    rd(5'd13, d); check("t5_w1c", 32'(d[23:16]), 32'h0);
    rfe_pulse(); #1;
    check("t5_no_catch", 32'(bus.o_ie_catch), 32'h0);
    exc_pulse(5'b00001);
    bus.i_interrupts = 8'h04;
    wr(5'd13, 32'h00040000);
    bus.i_interrupts = '0;
    rd(5'd13, d); check("t5_set_wins", 32'(d[23:16]), 32'h04);
    rfe_pulse(); #1;
    check("t5_code", 32'(bus.o_code), 32'd18);
    @(negedge clk);
    rd(5'd12, d); check("t5_status", d, 32'h00FF061F);
    rd(5'd13, d); check("t5_autoclr", 32'(d[23:16]), 32'h0);
    rfe_pulse();
    // reset while in a handler with a pending edge
    exc_pulse(5'b00001);
    int_pulse(8'h02);
    #2 arst_n = 1'b0;
    #3 arst_n = 1'b1;
    @(negedge clk);
    rd(5'd12, d); check("rst2_status", d, 32'h00FF071F);
    rd(5'd13, d); check("rst2_cause", d, 32'h0);
    rd(5'd14, d); check("rst2_epc", d, 32'h0);
`ifdef CP0_TIMER_EN
    wr(5'd11, 32'd20);
    wr(5'd9, 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = bus.o_timer_irq;
    end
    check("t6_timer_set", 32'(hit), 32'h1);
    hit = 1'b0;
    for (int i = 0; i < 5 && !hit; i++) begin
      #1 hit = bus.o_ie_catch;
      if (!hit) @(negedge clk);
    end
    check("t6_catch", 32'(hit), 32'h1);
    check("t6_code", 32'(bus.o_code), 32'd23);
    @(negedge clk);
    wr(5'd11, 32'd20); #1;
    check("t6_clear", 32'(bus.o_timer_irq), 32'h0);
    rfe_pulse();
`else
    wr(5'd9, 32'h1234);
    rd(5'd9, d); check("no_count", d, 32'h0);
    check("timer_tied", 32'(bus.o_timer_irq), 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
